mem_port_arbiter: RTL and testbench

- Shares the single synchronous unified memory port between two requesters: port 0 is the multicycle CPU load/store/fetch path, port 1 is a loader/debug master.
- Latches the winning request and drives one memory access.
- Waits a fixed read latency, registers the read data and returns it with a one-cycle valid pulse.
- Sits between the CPU datapath memory mux and the memory macro. Timing is deterministic, so CPU wait states remain fixed-count.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single synchronous memory port with a fixed read latency.
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN to break ties against the previous owner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,

    output logic [DATA_W-1:0]     rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any_req;
    logic              w_tie;
    logic              w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic [STRB_W-1:0] w_win_wstrb;
    logic              w_access;
    logic              w_resp;

    // A lone requester always wins; on a tie the fixed build favours port 0 and
    // the round-robin build favours whichever port did not own the last grant.
    assign w_any_req   = m0_req | m1_req;
    assign w_tie       = m0_req & m1_req;
    assign w_win       = w_tie ? (RR_EN & ~r_last_owner) : ~m0_req;

    assign w_win_we    = w_win ? m1_we    : m0_we;
    assign w_win_addr  = w_win ? m1_addr  : m0_addr;
    assign w_win_wdata = w_win ? m1_wdata : m0_wdata;
    assign w_win_wstrb = w_win ? m1_wstrb : m0_wstrb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_win;
                        r_we    <= w_win_we;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                        r_wstrb <= w_win_wstrb;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_last_owner <= r_owner;
                    if (r_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Counter reaches zero in the cycle mem_rdata becomes valid.
                    if (r_cnt == '0) begin
                        r_rdata <= mem_rdata;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_access  = (r_state == ST_ACCESS);
    assign w_resp    = (r_state == ST_RESP);

    assign m0_gnt    = w_access & ~r_owner;
    assign m1_gnt    = w_access &  r_owner;
    assign m0_rvalid = w_resp   & ~r_owner;
    assign m1_rvalid = w_resp   &  r_owner;

    assign rdata     = r_rdata;

    // Address and write data stay parked on the last latched request between strobes.
    assign mem_en    = w_access;
    assign mem_we    = w_access & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = (w_access & r_we) ? r_wstrb : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at read latency 1, one at read latency 4.
// Honours MEM_PORT_ARBITER_ROUND_ROBIN_EN for the expected tie-break.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic [3:0]  m0_wstrb;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [3:0]  m1_wstrb;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        m0_gnt;
        logic        m0_rvalid;
        logic        m1_gnt;
        logic        m1_rvalid;
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic [31:0] rdata;
    } out_t;

    typedef struct {
        logic chk;
        in_t  i;
        out_t e;
    } vec_t;

    logic clk = 1'b0;
    in_t  din  [2];
    out_t dout [2];
    vec_t tbl  [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        out_t o;
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .RD_LATENCY(g == 0 ? 1 : 4)
        ) u_dut (
            .clk(clk), .reset(din[g].rst),
            .m0_req(din[g].m0_req), .m0_we(din[g].m0_we), .m0_addr(din[g].m0_addr),
            .m0_wdata(din[g].m0_wdata), .m0_wstrb(din[g].m0_wstrb),
            .m0_gnt(o.m0_gnt), .m0_rvalid(o.m0_rvalid),
            .m1_req(din[g].m1_req), .m1_we(din[g].m1_we), .m1_addr(din[g].m1_addr),
            .m1_wdata(din[g].m1_wdata), .m1_wstrb(din[g].m1_wstrb),
            .m1_gnt(o.m1_gnt), .m1_rvalid(o.m1_rvalid),
            .rdata(o.rdata),
            .mem_en(o.mem_en), .mem_we(o.mem_we), .mem_addr(o.mem_addr),
            .mem_wdata(o.mem_wdata), .mem_wstrb(o.mem_wstrb),
            .mem_rdata(din[g].mem_rdata)
        );
        assign dout[g] = o;
    end

    task automatic chk_out(input string nm, input out_t act, input out_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got gnt=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h ws=%h rd=%h, expected gnt=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h ws=%h rd=%h",
                      nm, act.m0_gnt, act.m1_gnt, act.m0_rvalid, act.m1_rvalid, act.mem_en, act.mem_we,
                      act.mem_addr, act.mem_wdata, act.mem_wstrb, act.rdata,
                      exp.m0_gnt, exp.m1_gnt, exp.m0_rvalid, exp.m1_rvalid, exp.mem_en, exp.mem_we,
                      exp.mem_addr, exp.mem_wdata, exp.mem_wstrb, exp.rdata);
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic in_t vi(input logic [31:0] rst,
                               input logic [31:0] r0, we0, a0, wd0, ws0,
                               input logic [31:0] r1, we1, a1, wd1, ws1,
                               input logic [31:0] rd);
        in_t v;
        v.rst = rst[0];
        v.m0_req = r0[0]; v.m0_we = we0[0]; v.m0_addr = a0; v.m0_wdata = wd0; v.m0_wstrb = ws0[3:0];
        v.m1_req = r1[0]; v.m1_we = we1[0]; v.m1_addr = a1; v.m1_wdata = wd1; v.m1_wstrb = ws1[3:0];
        v.mem_rdata = rd;
        return v;
    endfunction

    function automatic out_t vo(input logic [31:0] g0, v0, g1, v1, en, we,
                                input logic [31:0] addr, wdata, wstrb, rd);
        out_t v;
        v.m0_gnt = g0[0]; v.m0_rvalid = v0[0]; v.m1_gnt = g1[0]; v.m1_rvalid = v1[0];
        v.mem_en = en[0]; v.mem_we = we[0]; v.mem_addr = addr; v.mem_wdata = wdata;
        v.mem_wstrb = wstrb[3:0]; v.rdata = rd;
        return v;
    endfunction

    task automatic add(input logic c, input in_t i, input out_t e);
        vec_t v;
        v.chk = c; v.i = i; v.e = e;
        tbl.push_back(v);
    endtask

    // Each row: outputs expected during the cycle, then inputs applied for that cycle.
    task automatic run_table();
        in_t  z, both, wr;
        logic [31:0] DB, SA;
        DB = 32'hDEADBEEF;
        SA = 32'h5555AAAA;
        z    = '0;
        both = vi(0, 1, 1, 'h30, 'hA0A0A0A0, 1, 1, 1, 'h40, 'hB0B0B0B0, 2, 0);
        wr   = vi(0, 1, 1, 'h54, 'hCAFEF00D, 3, 0, 0, 0, 0, 0, 0);
        add(0, vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '0);
        add(1, vi(0, 1, 0, 'h10, 0, 'hF, 0, 0, 0, 0, 0, 0), '0);
        add(1, vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h11111111), vo(1, 0, 0, 0, 1, 0, 'h10, 0, 0, 0));
        add(1, vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DB), vo(0, 0, 0, 0, 0, 0, 'h10, 0, 0, 0));
        add(1, vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h22222222), vo(0, 1, 0, 0, 0, 0, 'h10, 0, 0, DB));
        add(1, vi(0, 0, 0, 0, 0, 0, 1, 1, 'h20, 'h12345678, 'hF, 0), vo(0, 0, 0, 0, 0, 0, 'h10, 0, 0, DB));
        add(1, z, vo(0, 0, 1, 0, 1, 1, 'h20, 'h12345678, 'hF, DB));
        add(1, both, vo(0, 0, 0, 0, 0, 0, 'h20, 'h12345678, 0, DB));
        add(1, both, vo(1, 0, 0, 0, 1, 1, 'h30, 'hA0A0A0A0, 1, DB));
        add(1, both, vo(0, 0, 0, 0, 0, 0, 'h30, 'hA0A0A0A0, 0, DB));
        add(1, both, RR ? vo(0, 0, 1, 0, 1, 1, 'h40, 'hB0B0B0B0, 2, DB)
                        : vo(1, 0, 0, 0, 1, 1, 'h30, 'hA0A0A0A0, 1, DB));
        add(1, both, RR ? vo(0, 0, 0, 0, 0, 0, 'h40, 'hB0B0B0B0, 0, DB)
                        : vo(0, 0, 0, 0, 0, 0, 'h30, 'hA0A0A0A0, 0, DB));
        add(1, z, vo(1, 0, 0, 0, 1, 1, 'h30, 'hA0A0A0A0, 1, DB));
        add(1, vi(0, 1, 0, 'h50, 0, 'hF, 0, 0, 0, 0, 0, 0), vo(0, 0, 0, 0, 0, 0, 'h30, 'hA0A0A0A0, 0, DB));
        add(1, vi(0, 1, 1, 'h54, 'hCAFEF00D, 3, 0, 0, 0, 0, 0, 'h99999999), vo(1, 0, 0, 0, 1, 0, 'h50, 0, 0, DB));
        add(1, vi(0, 1, 1, 'h54, 'hCAFEF00D, 3, 0, 0, 0, 0, 0, SA), vo(0, 0, 0, 0, 0, 0, 'h50, 0, 0, DB));
        add(1, wr, vo(0, 1, 0, 0, 0, 0, 'h50, 0, 0, SA));
        add(1, wr, vo(0, 0, 0, 0, 0, 0, 'h50, 0, 0, SA));
        add(1, z, vo(1, 0, 0, 0, 1, 1, 'h54, 'hCAFEF00D, 3, SA));
        add(1, z, vo(0, 0, 0, 0, 0, 0, 'h54, 'hCAFEF00D, 0, SA));
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            if (tbl[k].chk) chk_out($sformatf("vec%0d", k), dout[0], tbl[k].e);
            din[0] = tbl[k].i;
        end
    endtask

    // Read latency 4: a request raised while busy is only sampled once the read retires.
    task automatic seq_latency4();
        out_t o;
        @(negedge clk);
        din[1] = '0; din[1].rst = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            o = dout[1];
            if (c == 0) chk_out("lat4_reset", o, '0);
            chk_bit($sformatf("lat4_m0_gnt c%0d", c), o.m0_gnt, c == 1);
            chk_bit($sformatf("lat4_mem_en c%0d", c), o.mem_en, c == 1 || c == 8);
            chk_bit($sformatf("lat4_m0_rvalid c%0d", c), o.m0_rvalid, c == 6);
            chk_bit($sformatf("lat4_m1_gnt c%0d", c), o.m1_gnt, c == 8);
            chk_bit($sformatf("lat4_m1_rvalid c%0d", c), o.m1_rvalid, c == 13);
            if (c == 1) chk_word("lat4_addr0", o.mem_addr, 32'h60);
            if (c == 8) chk_word("lat4_addr1", o.mem_addr, 32'h70);
            if (c == 6) chk_word("lat4_rdata0", o.rdata, 32'hFEEDF00D);
            if (c == 13) chk_word("lat4_rdata1", o.rdata, 32'h0F0F0F0F);
            din[1] = '0;
            if (c == 0) begin din[1].m0_req = 1'b1; din[1].m0_addr = 32'h60; end
            if (c >= 2 && c < 8) begin din[1].m1_req = 1'b1; din[1].m1_addr = 32'h70; end
            din[1].mem_rdata = (c == 5) ? 32'hFEEDF00D : (c == 12) ? 32'h0F0F0F0F : $urandom;
        end
    endtask

    // Reset lands during the read wait; the abandoned read must never respond.
    task automatic seq_reset_mid_read();
        out_t o;
        @(negedge clk);
        din[1] = '0; din[1].rst = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            o = dout[1];
            if (c == 3) chk_out("rst_outputs_zero", o, '0);
            chk_bit($sformatf("rst_m0_rvalid c%0d", c), o.m0_rvalid, 1'b0);
            chk_bit($sformatf("rst_mem_en c%0d", c), o.mem_en, c == 1 || c == 4);
            chk_bit($sformatf("rst_m1_gnt c%0d", c), o.m1_gnt, c == 4);
            chk_bit($sformatf("rst_m1_rvalid c%0d", c), o.m1_rvalid, c == 9);
            if (c == 9) chk_word("rst_m1_rdata", o.rdata, 32'h13572468);
            din[1] = '0;
            if (c == 0) begin din[1].m0_req = 1'b1; din[1].m0_addr = 32'h90; end
            if (c == 2) din[1].rst = 1'b1;
            if (c == 3) begin din[1].m1_req = 1'b1; din[1].m1_addr = 32'hA0; end
            din[1].mem_rdata = (c == 5) ? 32'hBAD0BAD0 : (c == 8) ? 32'h13572468 : $urandom;
        end
    endtask

    // Transaction-level reference: a free port accepts one request; its grant,
    // response and next sampling slot follow from the read latency alone.
    task automatic rand_run(input int idx, input int lat, input int ncyc);
        logic [31:0] hist [$];
        logic        rq [2];
        logic        wr [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic [3:0]  ws [2];
        int          free_at = 0, last = 1, s = -100, own = 0, w = 0;
        logic        busy = 1'b0, twe = 1'b0;
        logic [31:0] ta = '0, twd = '0, e_addr = '0, e_wdata = '0, e_rdata = '0;
        logic [3:0]  tws = '0;
        out_t        e, o;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wd[p] = '0; ws[p] = '0;
        end
        @(negedge clk);
        din[idx] = '0; din[idx].rst = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            e = '0;
            if (busy && c == s + 1) begin
                e_addr = ta; e_wdata = twd;
                e.mem_en = 1'b1; e.mem_we = twe; e.mem_wstrb = twe ? tws : 4'h0;
                e.m0_gnt = (own == 0); e.m1_gnt = (own == 1);
            end
            if (busy && !twe && c == s + 2 + lat) begin
                e_rdata = hist[s + 1 + lat];
                e.m0_rvalid = (own == 0); e.m1_rvalid = (own == 1);
            end
            e.mem_addr = e_addr; e.mem_wdata = e_wdata; e.rdata = e_rdata;
            o = dout[idx];
            if (!e.mem_en) o.mem_wstrb = '0;
            chk_out($sformatf("rand%0d c%0d", idx, c), o, e);

            din[idx] = '0;
            din[idx].mem_rdata = $urandom;
            hist.push_back(din[idx].mem_rdata);
            if (c > 8 && $urandom_range(0, 99) == 0) begin
                busy = 1'b0; free_at = c + 1; last = 1;
                e_addr = '0; e_wdata = '0; e_rdata = '0;
                rq[0] = 1'b0; rq[1] = 1'b0;
                din[idx].rst = 1'b1;
                continue;
            end
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && (p == 0 ? e.m0_gnt : e.m1_gnt)) rq[p] = 1'b0;
                else if (rq[p] && $urandom_range(0, 15) == 0) rq[p] = 1'b0;
                else if (!rq[p] && $urandom_range(0, 2) == 0) begin
                    rq[p] = 1'b1; wr[p] = 1'($urandom); ad[p] = $urandom;
                    wd[p] = $urandom; ws[p] = 4'($urandom);
                end
            end
            if (c >= free_at && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) w = RR ? 1 - last : 0;
                else w = rq[1] ? 1 : 0;
                own = w; busy = 1'b1; s = c; last = w;
                twe = wr[w]; ta = ad[w]; twd = wd[w]; tws = ws[w];
                free_at = twe ? c + 2 : c + 3 + lat;
            end
            din[idx].m0_req = rq[0]; din[idx].m0_we = wr[0]; din[idx].m0_addr = ad[0];
            din[idx].m0_wdata = wd[0]; din[idx].m0_wstrb = ws[0];
            din[idx].m1_req = rq[1]; din[idx].m1_we = wr[1]; din[idx].m1_addr = ad[1];
            din[idx].m1_wdata = wd[1]; din[idx].m1_wstrb = ws[1];
        end
    endtask

    initial begin
        din[0] = '0; din[0].rst = 1'b1;
        din[1] = '0; din[1].rst = 1'b1;
        run_table();
        seq_latency4();
        seq_reset_mid_read();
        fork
            rand_run(0, 1, 2500);
            rand_run(1, 4, 2500);
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
